// File: rtl/sum_accumulator_if.sv
// Operand-in / result-out handshake bundle for sum_accumulator.
// master drives operands and result backpressure; slave is the accumulator.
interface sum_accumulator_if #(
  parameter int unsigned W = 4
);
  logic [W-1:0] in_msg;
  logic         in_val;
  logic         in_rdy;
  logic [W-1:0] out_msg;
  logic         out_ovf;
  logic         out_val;
  logic         out_rdy;

  modport master (
    output in_msg, in_val, out_rdy,
    input  in_rdy, out_msg, out_ovf, out_val
  );

  modport slave (
    input  in_msg, in_val, out_rdy,
    output in_rdy, out_msg, out_ovf, out_val
  );
endinterface

// File: rtl/sum_accumulator.sv
// Accumulates NUM W-bit operands (mod 2^W) and emits the sum with a
// sticky carry-out flag over a val/rdy stream.
module sum_accumulator #(
  parameter int unsigned W   = 4,
  parameter int unsigned NUM = 4
) (
  input  logic              clk,
  input  logic              reset,
  sum_accumulator_if.slave  bus
);
  localparam int unsigned CW = (NUM > 1) ? $clog2(NUM) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(NUM - 1);

  typedef enum logic {ACCUM = 1'b0, DONE = 1'b1} state_t;

  state_t        state;
  state_t        state_nxt;
  logic          in_rdy_q;
  logic          out_val_q;
  logic          in_rdy_c;
  logic          out_val_c;
  logic [W-1:0]  acc;
  logic          ovf;
  logic [CW-1:0] cnt;
  logic [W:0]    sum_c;
  logic          in_fire;
  logic          out_fire;

  assign in_fire  = bus.in_val & in_rdy_q;
  assign out_fire = out_val_q & bus.out_rdy;
  assign sum_c    = {1'b0, acc} + {1'b0, bus.in_msg};

  // State register; handshake flags are registered copies of the state decode
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= ACCUM;
      in_rdy_q  <= 1'b1;
      out_val_q <= 1'b0;
    end else begin
      state     <= state_nxt;
      in_rdy_q  <= in_rdy_c;
      out_val_q <= out_val_c;
    end
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      ACCUM: if (in_fire && (cnt == CNT_LAST)) state_nxt = DONE;
      DONE:  if (out_fire) state_nxt = ACCUM;
      default: state_nxt = ACCUM;
    endcase
  end

  // Output decode, taken from the next state so the flags land with it
  always_comb begin
    in_rdy_c  = 1'b0;
    out_val_c = 1'b0;
    case (state_nxt)
      ACCUM:   in_rdy_c  = 1'b1;
      DONE:    out_val_c = 1'b1;
      default: in_rdy_c  = 1'b1;
    endcase
  end

  // Datapath: operand X is harmless since acc only loads on a fire
  always_ff @(posedge clk) begin
    if (reset) begin
      acc <= '0;
      ovf <= 1'b0;
      cnt <= '0;
    end else if (out_fire) begin
      acc <= '0;
      ovf <= 1'b0;
    end else if (in_fire) begin
      acc <= sum_c[W-1:0];
      ovf <= ovf | sum_c[W];
      cnt <= (cnt == CNT_LAST) ? '0 : cnt + CW'(1);
    end
  end

  assign bus.in_rdy  = in_rdy_q;
  assign bus.out_val = out_val_q;
  assign bus.out_msg = acc;
  assign bus.out_ovf = ovf;
endmodule
